// File: rtl/key_debounce_pulse.sv
// rtl/key_debounce_pulse.sv - per-key synchroniser, 4-state debouncer, press/release pulses.
// Optional macro LONG_PRESS_EN adds a per-key hold counter driving key_long.
module key_debounce_pulse #(
  parameter int NUM_KEYS        = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2000000,
  parameter int LONG_CYCLES     = 100000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] raw_keys,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } state_t;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_press_nxt;
    logic                   w_release_nxt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_sync <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], raw_keys[i]};
      end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state   <= S_LOW;
        r_cnt     <= '0;
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_state   <= w_state_nxt;
        r_cnt     <= w_cnt_nxt;
        r_level   <= (w_state_nxt == S_HIGH) || (w_state_nxt == S_WAIT_LOW);
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
      end
    end

    // Any disagreement during a wait state drops back without touching the level.
    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      case (r_state)
        S_LOW: begin
          if (w_sync) begin
            w_state_nxt = S_WAIT_HIGH;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!w_sync) begin
            w_state_nxt = S_LOW;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = S_HIGH;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_HIGH: begin
          if (!w_sync) begin
            w_state_nxt = S_WAIT_LOW;
            w_cnt_nxt   = '0;
          end
        end
        S_WAIT_LOW: begin
          if (w_sync) begin
            w_state_nxt = S_HIGH;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt   = S_LOW;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = S_LOW;
        end
      endcase
    end

    assign key_level[i]   = r_level;
    assign key_press[i]   = r_press;
    assign key_release[i] = r_release;

`ifdef LONG_PRESS_EN
    localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic [HOLD_W-1:0] r_hold;
    logic              r_long;

    // Saturating at HOLD_LAST gives one pulse per accepted press, no auto-repeat.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_hold <= '0;
        r_long <= 1'b0;
      end else begin
        r_long <= 1'b0;
        if (w_press_nxt) begin
          r_hold <= '0;
          r_long <= (HOLD_LAST == '0);
        end else if (((r_state == S_HIGH) || (r_state == S_WAIT_LOW)) && (r_hold != HOLD_LAST)) begin
          r_hold <= r_hold + 1'b1;
          r_long <= ((r_hold + 1'b1) == HOLD_LAST);
        end
      end
    end

    assign key_long[i] = r_long;
`else
    assign key_long[i] = 1'b0;
`endif
  end

endmodule
